// File: rtl/match_ctrl_if.sv
// rtl/match_ctrl_if.sv - player/tick inputs and game-state outputs of the tug-of-war match controller
//
// Purpose: bundles every match_ctrl signal except clk/rst.
// Ports (seen from the controller, modport slave):
//   slowen    in   one-clk slow tick enable
//   rand_bit  in   serial pseudo-random bit, new value every clk
//   pbl, pbr  in   left/right pushbutton pulses (already synchronized)
//   leds_on   out  GO indicator
//   position  out  rope position, 0 = left wins, 2*CENTER = right wins
//   ready_l/r out  player armed for the current round
//   winner    out  00 none, 01 left, 10 right, 11 void/tie
//   beep_req  out  one-clk beep pulse
//   state_o   out  current state encoding
interface match_ctrl_if;
  logic       slowen;
  logic       rand_bit;
  logic       pbl;
  logic       pbr;
  logic       leds_on;
  logic [3:0] position;
  logic       ready_l;
  logic       ready_r;
  logic [1:0] winner;
  logic       beep_req;
  logic [2:0] state_o;

  modport master (
    output slowen, rand_bit, pbl, pbr,
    input  leds_on, position, ready_l, ready_r, winner, beep_req, state_o
  );

  modport slave (
    input  slowen, rand_bit, pbl, pbr,
    output leds_on, position, ready_l, ready_r, winner, beep_req, state_o
  );
endinterface

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - round sequencer and scorekeeper for a two-player reaction tug-of-war
//
// Purpose: arms both players, waits a pseudo-random delay, lights GO, scores the
// first press, moves the rope and holds the result; a match ends when the rope
// reaches either end.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  match_ctrl_if.slave - tick/random/button inputs and game-state outputs
module match_ctrl #(
  parameter int CENTER     = 4,
  parameter int MIN_TICKS  = 8,
  parameter int GO_TIMEOUT = 64,
  parameter int HOLD_TICKS = 32
) (
  input  logic         clk,
  input  logic         rst,
  match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT  = 3'd2,
    GO    = 3'd3,
    SCORE = 3'd4,
    HOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_LEFT  = 2'b01;
  localparam logic [1:0] W_RIGHT = 2'b10;
  localparam logic [1:0] W_VOID  = 2'b11;

  localparam logic [3:0]  POS_MID   = 4'(CENTER);
  localparam logic [3:0]  POS_MAX   = 4'(2 * CENTER);
  localparam logic [15:0] GO_LAST   = 16'(GO_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);

  state_t      state, state_d;
  logic [3:0]  position, position_d;
  logic [1:0]  winner, winner_d;
  logic        ready_l, ready_l_d;
  logic        ready_r, ready_r_d;
  logic        leds_on, leds_on_d;
  logic        beep_req, beep_req_d;
  logic        beep_evt;
  logic [3:0]  shreg;
  // One counter serves the WAIT delay, the GO timeout and the HOLD time;
  // those states are mutually exclusive and each entry reloads it.
  logic [15:0] cnt, cnt_d;

  logic [15:0] delay_load;
  logic [3:0]  pos_inc, pos_dec;
  logic        both;

  assign delay_load = 16'(MIN_TICKS) + {12'd0, shreg};
  assign pos_inc    = (position >= POS_MAX) ? POS_MAX : position + 4'd1;
  assign pos_dec    = (position == 4'd0) ? 4'd0 : position - 4'd1;
  assign both       = bus.pbl && bus.pbr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      position <= POS_MID;
      winner   <= W_NONE;
      ready_l  <= 1'b0;
      ready_r  <= 1'b0;
      leds_on  <= 1'b0;
      beep_req <= 1'b0;
      shreg    <= 4'd0;
      cnt      <= 16'd0;
    end else begin
      state    <= state_d;
      position <= position_d;
      winner   <= winner_d;
      ready_l  <= ready_l_d;
      ready_r  <= ready_r_d;
      leds_on  <= leds_on_d;
      beep_req <= beep_req_d;
      shreg    <= {shreg[2:0], bus.rand_bit};
      cnt      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    position_d = position;
    winner_d   = winner;
    ready_l_d  = ready_l;
    ready_r_d  = ready_r;
    cnt_d      = cnt;
    beep_evt   = 1'b0;

    case (state)
      IDLE: begin
        ready_l_d = 1'b0;
        ready_r_d = 1'b0;
        state_d   = ARM;
      end

      ARM: begin
        if (bus.pbl) ready_l_d = 1'b1;
        if (bus.pbr) ready_r_d = 1'b1;
        if (ready_l_d && ready_r_d) begin
          state_d = WAIT;
          cnt_d   = delay_load;
        end
      end

      WAIT: begin
        if (both) begin
          // Simultaneous presses cancel out: fresh random delay, no score.
          cnt_d = delay_load;
        end else if (bus.pbl) begin
          winner_d   = W_RIGHT;
          position_d = pos_inc;
          beep_evt   = 1'b1;
          state_d    = HOLD;
          cnt_d      = 16'd0;
        end else if (bus.pbr) begin
          winner_d   = W_LEFT;
          position_d = pos_dec;
          beep_evt   = 1'b1;
          state_d    = HOLD;
          cnt_d      = 16'd0;
        end else if (bus.slowen) begin
          // GO is entered on the tick that brings the delay to zero.
          if (cnt <= 16'd1) begin
            state_d = GO;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt - 16'd1;
          end
        end
      end

      GO: begin
        if (both) begin
          winner_d = W_VOID;
          state_d  = HOLD;
          cnt_d    = 16'd0;
        end else if (bus.pbl) begin
          winner_d = W_LEFT;
          state_d  = SCORE;
        end else if (bus.pbr) begin
          winner_d = W_RIGHT;
          state_d  = SCORE;
        end else if (bus.slowen) begin
          if (cnt >= GO_LAST) begin
            winner_d = W_VOID;
            state_d  = HOLD;
            cnt_d    = 16'd0;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end

      SCORE: begin
        if (winner == W_LEFT) begin
          position_d = pos_dec;
        end else if (winner == W_RIGHT) begin
          position_d = pos_inc;
        end
        beep_evt = 1'b1;
        state_d  = HOLD;
        cnt_d    = 16'd0;
      end

      HOLD: begin
        if (bus.slowen) begin
          if (cnt >= HOLD_LAST) begin
            cnt_d   = 16'd0;
            state_d = ((position == 4'd0) || (position == POS_MAX)) ? DONE : IDLE;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end

      DONE: begin
        if (both) begin
          position_d = POS_MID;
          winner_d   = W_NONE;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    leds_on_d  = (state_d == GO);
    beep_req_d = beep_evt || (position_d != position);
  end

  assign bus.leds_on  = leds_on;
  assign bus.position = position;
  assign bus.ready_l  = ready_l;
  assign bus.ready_r  = ready_r;
  assign bus.winner   = winner;
  assign bus.beep_req = beep_req;
  assign bus.state_o  = state;

endmodule
